tt_um_cnt_ctrl: RTL and testbench
=================================

TT_UM_CNT_CTRL -- requirements
Module: tt_um_cnt_ctrl

Interface
REQ-001 The block SHALL have one clock: clk, input, 1 bit, rising-edge clock for all state.
REQ-002 The block SHALL have one reset: rst_n, input, 1 bit, asynchronous, active-low, clears all state.
REQ-003 The block SHALL have the input ena, 1 bit: when 1, the block is enabled; when 0, all state freezes and uio_oe is 0.
REQ-004 The block SHALL have the input ui_in, 8 bits, the command data byte (start or terminal value).
REQ-005 The block SHALL have the input uio_in, 8 bits: [0] cmd_valid; [2:1] opcode (00 LOAD_START, 01 LOAD_TERM, 10 RUN, 11 STOP); [7:3] ignored.
REQ-006 The block SHALL have the output uo_out, 8 bits, the current counter value cnt.
REQ-007 The block SHALL have the output uio_out, 8 bits: [2:0] 0; [3] cmd_ready; [4] busy (state RUN); [5] done (state DONE); [6] wrap pulse; [7] paused (state PAUSE).
REQ-008 The block SHALL have the output uio_oe, 8 bits: 8'hF8 when ena=1, 8'h00 when ena=0.

Function
REQ-009 The controller SHALL use states IDLE, RUN, PAUSE and DONE, and hold registers cnt[7:0], start_reg[7:0] and term_reg[7:0].
REQ-010 A command SHALL be accepted on a clk edge with ena=1, cmd_valid=1 and cmd_ready=1; acceptance uses the opcode and ui_in sampled on that edge.
REQ-011 cmd_ready SHALL go 0 on the edge after an accept and return to 1 on the first edge with ena=1 and cmd_valid=0; holding cmd_valid high issues exactly one command.
REQ-012 LOAD_START SHALL set start_reg to ui_in; it SHALL also set cnt to ui_in in IDLE, PAUSE and DONE; in RUN, cnt is unaffected.
REQ-013 LOAD_TERM SHALL set term_reg to ui_in in any state; the terminal compare on the accept cycle uses the old term_reg.
REQ-014 RUN SHALL cause the transitions IDLE->RUN, PAUSE->RUN and DONE->RUN; from DONE, cnt is also set to start_reg; in RUN, the command is a no-op.
REQ-015 STOP SHALL cause RUN->PAUSE with cnt held, and PAUSE->IDLE or DONE->IDLE with cnt set to start_reg; in IDLE, the command is a no-op.
REQ-016 In RUN with ena=1 and no accepted command, cnt SHALL increment by 1 each cycle, modulo 256 (8'hFF->8'h00 is not terminal unless term_reg=8'h00).
REQ-017 Terminal SHALL be the RUN cycle where cnt==term_reg; the behaviour is per REQ-024/REQ-025, and cnt is never incremented past term_reg.
REQ-018 When STOP is accepted on a terminal cycle, STOP SHALL win: PAUSE, cnt held, no done, no wrap.
REQ-019 The wrap output SHALL be high for exactly one cycle per auto-reload event, and 0 otherwise.
REQ-020 Outputs SHALL be registered; RUN SHALL be visible on uio_out[4] one cycle after accept; the first increment SHALL occur on the edge after RUN is entered.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state=IDLE, cnt=8'h00, start_reg=8'h00, term_reg=8'hFF, cmd_ready=1 and wrap=0, and hence uo_out=8'h00 and uio_out=8'h08.
REQ-022 Reset asserted mid-RUN SHALL abort the run immediately with no done or wrap; release SHALL be synchronous to the next clk edge.

Configuration
REQ-023 The macro CNT_CTRL_AUTORELOAD_EN SHALL select the terminal behaviour.
REQ-024 When CNT_CTRL_AUTORELOAD_EN is undefined, the terminal cycle SHALL cause RUN->DONE with cnt held at term_reg, and done=1 until the next RUN or STOP.
REQ-025 When CNT_CTRL_AUTORELOAD_EN is defined, the terminal cycle SHALL set cnt to start_reg, pulse wrap for 1 cycle, and stay in RUN; DONE is unreachable.

Verification
REQ-026 Reset, then LOAD_START 8'h10, LOAD_TERM 8'h14, RUN -> uo_out sequence 10,11,12,13,14, then done=1 and uo_out holds 8'h14 (no macro).
REQ-027 Same stimulus with CNT_CTRL_AUTORELOAD_EN -> 10..14,10,11..., with wrap high exactly on the cycle cnt returns to 8'h10, and done stays 0.
REQ-028 Start 8'hFE, term 8'h01, RUN -> FE,FF,00,01 and terminal at 8'h01; modulo wrap 8'hFF->8'h00 does not pulse wrap.
REQ-029 cmd_valid held high for 5 cycles with RUN -> one accept, cmd_ready low until cmd_valid drops; ena=0 for 3 cycles mid-RUN -> cnt frozen, uio_oe=8'h00.
REQ-030 STOP on the terminal cycle -> PAUSE with cnt=term, done=0; a second STOP -> IDLE with cnt=start_reg; rst_n pulsed mid-RUN -> uo_out=8'h00 at once, state IDLE.

Source files
------------

// File: rtl/tt_um_cnt_ctrl.sv
// Command-driven 8-bit counter controller (IDLE/RUN/PAUSE/DONE) on the TinyTapeout pinout.
// Define CNT_CTRL_AUTORELOAD_EN to reload from start_reg on terminal instead of stopping in DONE.
module tt_um_cnt_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned W = 8;
  localparam logic [1:0] OP_LOAD_START = 2'b00;
  localparam logic [1:0] OP_LOAD_TERM  = 2'b01;
  localparam logic [1:0] OP_RUN        = 2'b10;
  localparam logic [1:0] OP_STOP       = 2'b11;
  localparam logic [W-1:0] OE_MASK     = 8'hF8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   start_q, start_d;
  logic [W-1:0]   term_q, term_d;
  logic           ready_q, ready_d;
  logic           wrap_q, wrap_d;

  logic           cmd_valid;
  logic [1:0]     opcode;
  logic           accept;
  logic           terminal;
  logic           unused_uio_bits;

  assign cmd_valid       = uio_in[0];
  assign opcode          = uio_in[2:1];
  assign unused_uio_bits = ^uio_in[7:3];
  assign accept          = ena & cmd_valid & ready_q;
  assign terminal        = (cnt_q == term_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      term_q  <= '1;
      ready_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      term_q  <= term_d;
      ready_q <= ready_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    term_d  = term_q;
    ready_d = ready_q;
    wrap_d  = 1'b0;

    if (ena) begin
      // One command per cmd_valid assertion: re-arm only once valid drops.
      if (accept)          ready_d = 1'b0;
      else if (!cmd_valid) ready_d = 1'b1;

      if (accept && opcode == OP_LOAD_START) start_d = ui_in;
      if (accept && opcode == OP_LOAD_TERM)  term_d  = ui_in;

      case (state_q)
        S_RUN: begin
          if (accept && opcode == OP_STOP) begin
            state_d = S_PAUSE;
          end else if (terminal) begin
`ifdef CNT_CTRL_AUTORELOAD_EN
            cnt_d  = start_q;
            wrap_d = 1'b1;
`else
            state_d = S_DONE;
`endif
          end else if (!accept) begin
            cnt_d = cnt_q + W'(1);
          end
        end
        S_PAUSE, S_DONE: begin
          if (accept) begin
            case (opcode)
              OP_LOAD_START: cnt_d = ui_in;
              OP_RUN: begin
                state_d = S_RUN;
                if (state_q == S_DONE) cnt_d = start_q;
              end
              OP_STOP: begin
                state_d = S_IDLE;
                cnt_d   = start_q;
              end
              default: ;
            endcase
          end
        end
        default: begin
          if (accept) begin
            if (opcode == OP_LOAD_START) cnt_d = ui_in;
            if (opcode == OP_RUN)        state_d = S_RUN;
          end
        end
      endcase
    end
  end

  assign uo_out  = cnt_q;
  assign uio_out = {state_q == S_PAUSE, wrap_q, state_q == S_DONE, state_q == S_RUN,
                    ready_q, 3'b000};
  assign uio_oe  = ena ? OE_MASK : '0;

endmodule

// File: tb/tb_tt_um_cnt_ctrl.sv
// Randomized + directed bench for tt_um_cnt_ctrl against a behavioural command/counter model.
// Works for both builds (CNT_CTRL_AUTORELOAD_EN defined or not).
module tb_tt_um_cnt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_cnt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam logic [1:0] LD_S = 2'd0, LD_T = 2'd1, GO = 2'd2, HALT = 2'd3;

  int m_mode, m_cnt, m_start, m_term;
  bit m_ready, m_wrap;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_start = 0; m_term = 255; m_ready = 1; m_wrap = 0;
  endfunction

  // Behaviour of one clock edge, written from the command rules.
  function automatic void model_edge(input bit e, input bit v, input logic [1:0] op,
                                     input int d);
    int o_mode, o_cnt, o_start, o_term;
    bit acc;
    m_wrap = 0;
    if (!e) return;
    o_mode = m_mode; o_cnt = m_cnt; o_start = m_start; o_term = m_term;
    acc = v && m_ready;
    if (acc) m_ready = 0;
    else if (!v) m_ready = 1;
    if (acc) begin
      if (op == LD_S) begin
        m_start = d;
        if (o_mode != M_RUN) m_cnt = d;
      end else if (op == LD_T) begin
        m_term = d;
      end else if (op == GO) begin
        if (o_mode == M_DONE) m_cnt = o_start;
        m_mode = M_RUN;
      end else begin
        if (o_mode == M_RUN) m_mode = M_PAUSE;
        else if (o_mode != M_IDLE) begin
          m_mode = M_IDLE;
          m_cnt = o_start;
        end
      end
    end
    if (o_mode == M_RUN && !(acc && op == HALT)) begin
      if (o_cnt == o_term) begin
`ifdef CNT_CTRL_AUTORELOAD_EN
        m_cnt = o_start;
        m_wrap = 1;
`else
        m_mode = M_DONE;
`endif
      end else if (!acc) begin
        m_cnt = (o_cnt + 1) % 256;
      end
    end
  endfunction

  function automatic logic [7:0] exp_uio();
    return {m_mode == M_PAUSE, m_wrap, m_mode == M_DONE, m_mode == M_RUN, m_ready, 3'b000};
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".cnt"}, uo_out, 8'(m_cnt));
    check_eq({tag, ".flags"}, uio_out, exp_uio());
    check_eq({tag, ".oe"}, uio_oe, ena ? 8'hF8 : 8'h00);
  endtask

  task automatic step(input bit e, input bit v, input logic [1:0] op, input logic [7:0] d);
    ena = e; uio_in = {5'b00000, op, v}; ui_in = d;
    @(posedge clk);
    model_edge(e, v, op, int'(d));
    #1;
    compare_all("step");
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    step(1, 1, op, d);
    step(1, 0, 2'd0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_eq("rst.cnt", uo_out, 8'h00);
    check_eq("rst.uio", uio_out, 8'h08);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("por.cnt", uo_out, 8'h00);
    check_eq("por.uio", uio_out, 8'h08);
    check_eq("por.oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run: 10..14 then terminal
    issue(LD_S, 8'h10);
    issue(LD_T, 8'h14);
    step(1, 1, GO, 8'h00);
    check_eq("run.first", uo_out, 8'h10);
    check_eq("run.busy", {7'b0, uio_out[4]}, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 2'd0, 8'h00);
      check_eq("run.seq", uo_out, 8'(8'h10 + i));
    end
    step(1, 0, 2'd0, 8'h00);
`ifdef CNT_CTRL_AUTORELOAD_EN
    check_eq("reload.cnt", uo_out, 8'h10);
    check_eq("reload.wrap", {7'b0, uio_out[6]}, 8'h01);
    step(1, 0, 2'd0, 8'h00);
    check_eq("reload.next", uo_out, 8'h11);
    check_eq("reload.wrap0", {7'b0, uio_out[6]}, 8'h00);
`else
    check_eq("done.bit", {7'b0, uio_out[5]}, 8'h01);
    check_eq("done.hold", uo_out, 8'h14);
    step(1, 0, 2'd0, 8'h00);
    check_eq("done.hold2", uo_out, 8'h14);
`endif

    // Modulo wrap through FF->00 is not terminal
    do_reset();
    issue(LD_S, 8'hFE);
    issue(LD_T, 8'h01);
    step(1, 1, GO, 8'h00);
    step(1, 0, 2'd0, 8'h00);
    check_eq("mod.ff", uo_out, 8'hFF);
    step(1, 0, 2'd0, 8'h00);
    check_eq("mod.00", uo_out, 8'h00);
    check_eq("mod.nowrap", {7'b0, uio_out[6]}, 8'h00);
    step(1, 0, 2'd0, 8'h00);
    check_eq("mod.01", uo_out, 8'h01);
    step(1, 0, 2'd0, 8'h00);
`ifdef CNT_CTRL_AUTORELOAD_EN
    check_eq("mod.reload", uo_out, 8'hFE);
`else
    check_eq("mod.done", {7'b0, uio_out[5]}, 8'h01);
`endif

    // Held cmd_valid issues one command; ena=0 freezes
    do_reset();
    issue(LD_T, 8'h50);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, GO, 8'h00);
      check_eq("hold.ready", {7'b0, uio_out[3]}, 8'h00);
    end
    check_eq("hold.cnt", uo_out, 8'h04);
    step(1, 0, 2'd0, 8'h00);
    check_eq("hold.rearm", {7'b0, uio_out[3]}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'd0, 8'h00);
      check_eq("ena0.cnt", uo_out, 8'h05);
      check_eq("ena0.oe", uio_oe, 8'h00);
    end

    // STOP on the terminal cycle wins, second STOP returns to IDLE
    do_reset();
    issue(LD_S, 8'h20);
    issue(LD_T, 8'h23);
    step(1, 1, GO, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 2'd0, 8'h00);
    check_eq("term.at", uo_out, 8'h23);
    step(1, 1, HALT, 8'h00);
    check_eq("stop.cnt", uo_out, 8'h23);
    check_eq("stop.flags", uio_out & 8'hF0, 8'h80);
    step(1, 0, 2'd0, 8'h00);
    issue(HALT, 8'h00);
    check_eq("stop2.cnt", uo_out, 8'h20);
    check_eq("stop2.flags", uio_out & 8'hF0, 8'h00);

    // Reset mid-run
    issue(GO, 8'h00);
    step(1, 0, 2'd0, 8'h00);
    do_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit e, v;
      logic [1:0] op;
      logic [7:0] d;
      e  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 9) < 3);
      op = 2'($urandom_range(0, 3));
      if (op == HALT && $urandom_range(0, 2) != 0) op = GO;
      d  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      step(e, v, op, d);
      if ($urandom_range(0, 699) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
